// File: rtl/iir_pkg.sv
// +----------------------------------------------------------------------------+
// | iir_pkg : shared constants for the IIR cascade controller                  |
// | Holds the FSM state encoding, coefficient slot addresses and the default   |
// | coefficient width.                                                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package iir_pkg;

    localparam int DEF_COEFF_W = 16;

    localparam logic [1:0] ST_CFG  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_END  = 2'd3;

    localparam logic [1:0] SLOT_A1 = 2'd0;
    localparam logic [1:0] SLOT_A2 = 2'd1;
    localparam logic [1:0] SLOT_B  = 2'd2;
    localparam logic [1:0] SLOT_K  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/iir_ce_gen.sv
// +----------------------------------------------------------------------------+
// | iir_ce_gen : compute-enable window generator                               |
// | Produces a CE_LEN-cycle ce window after start, mult_sel in window cycle 1, |
// | and win_last flagging the final ce cycle.                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module iir_ce_gen #(
    parameter int CE_LEN = 3
) (
    input  logic clk,
    input  logic nrst,
    input  logic start,
    output logic ce,
    output logic mult_sel,
    output logic win_last
);

    logic       ce_q, ce_d;
    logic       mult_sel_q, mult_sel_d;
    logic [2:0] cnt_q, cnt_d;

    assign win_last = ce_q && (cnt_q == 3'(CE_LEN - 1));

    always_comb begin
        ce_d       = ce_q;
        cnt_d      = cnt_q;
        mult_sel_d = 1'b0;
        if (start) begin
            ce_d  = 1'b1;
            cnt_d = 3'd0;
        end else if (ce_q) begin
            if (win_last) begin
                ce_d  = 1'b0;
                cnt_d = 3'd0;
            end else begin
                cnt_d      = cnt_q + 3'd1;
                // registered, so raising it in cycle 0 lands it on cycle 1
                mult_sel_d = (cnt_q == 3'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ce_q       <= 1'b0;
            cnt_q      <= 3'd0;
            mult_sel_q <= 1'b0;
        end else begin
            ce_q       <= ce_d;
            cnt_q      <= cnt_d;
            mult_sel_q <= mult_sel_d;
        end
    end

    assign ce       = ce_q;
    assign mult_sel = mult_sel_q;

endmodule

`default_nettype wire

// File: rtl/iir_ctrl.sv
// +----------------------------------------------------------------------------+
// | iir_ctrl : controller for a cascade of N_SECT second-order IIR sections    |
// | Loads coefficients, sequences compute windows, tracks pipeline fill and    |
// | dropped samples. Macro IIR_CTRL_OVR_CNT_EN enables the ovr_cnt counter.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module iir_ctrl
    import iir_pkg::*;
#(
    parameter int N_SECT  = 4,
    parameter int COEFF_W = DEF_COEFF_W,
    parameter int CE_LEN  = 3
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               cfg_valid,
    input  logic [COEFF_W-1:0] cfg_data,
    output logic               cfg_ready,
    input  logic               cfg_start,
    input  logic               samp_valid,
    output logic               ce,
    output logic               mult_sel,
    output logic               c_we,
    output logic [1:0]         c_addr,
    output logic [COEFF_W-1:0] c_in,
    output logic [N_SECT-1:0]  c_sect,
    output logic               out_valid,
    output logic               overrun,
    output logic [7:0]         ovr_cnt
);

    localparam int N_WORDS = 4 * N_SECT;
    localparam int WORD_W  = $clog2(N_WORDS);
    localparam int FILL_W  = $clog2(N_SECT + 1);

    logic [1:0]         state_q, state_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               c_we_q, c_we_d;
    logic [1:0]         c_addr_q, c_addr_d;
    logic [COEFF_W-1:0] c_in_q, c_in_d;
    logic [N_SECT-1:0]  c_sect_q, c_sect_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;

    logic              hs;
    logic              start;
    logic              enter_cfg;
    logic              drop;
    logic              win_last;
    logic [N_SECT-1:0] sect_hit;

    assign hs = cfg_valid && cfg_ready_q;

    for (genvar s = 0; s < N_SECT; s++) begin : g_sect
        assign sect_hit[s] = ((32'(word_q) >> 2) == 32'(s));
    end

    iir_ce_gen #(
        .CE_LEN   (CE_LEN)
    ) u_ce_gen (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start),
        .ce       (ce),
        .mult_sel (mult_sel),
        .win_last (win_last)
    );

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        fill_d      = fill_q;
        out_valid_d = 1'b0;
        start       = 1'b0;
        enter_cfg   = 1'b0;
        drop        = 1'b0;
        case (state_q)
            ST_CFG: begin
                drop = samp_valid;
                if (hs) begin
                    if (word_q == WORD_W'(N_WORDS - 1)) begin
                        word_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            ST_IDLE, ST_END: begin
                if (state_q == ST_END) begin
                    // fill is checked before this END's increment
                    out_valid_d = (fill_q >= FILL_W'(N_SECT - 1));
                    if (fill_q != FILL_W'(N_SECT)) fill_d = fill_q + 1'b1;
                end
                if (cfg_start) begin
                    state_d   = ST_CFG;
                    enter_cfg = 1'b1;
                end else if (samp_valid) begin
                    state_d = ST_RUN;
                    start   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                drop = samp_valid;
                if (win_last) state_d = ST_END;
            end
            default: state_d = ST_CFG;
        endcase
        if (enter_cfg) begin
            fill_d = '0;
            word_d = '0;
        end
    end

    always_comb begin
        cfg_ready_d = (state_d == ST_CFG);
        c_we_d      = hs;
        c_sect_d    = hs ? sect_hit : '0;
        c_addr_d    = hs ? word_q[1:0] : c_addr_q;
        c_in_d      = hs ? cfg_data : c_in_q;
        overrun_d   = enter_cfg ? 1'b0 : (overrun_q || drop);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_CFG;
            cfg_ready_q <= 1'b0;
            word_q      <= '0;
            fill_q      <= '0;
            c_we_q      <= 1'b0;
            c_addr_q    <= 2'd0;
            c_in_q      <= '0;
            c_sect_q    <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            word_q      <= word_d;
            fill_q      <= fill_d;
            c_we_q      <= c_we_d;
            c_addr_q    <= c_addr_d;
            c_in_q      <= c_in_d;
            c_sect_q    <= c_sect_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef IIR_CTRL_OVR_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (enter_cfg) begin
            ovr_cnt_d = 8'd0;
        end else if (drop && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ovr_cnt_q <= 8'd0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ovr_cnt = ovr_cnt_q;
`else
    assign ovr_cnt = 8'd0;
`endif

    assign cfg_ready = cfg_ready_q;
    assign c_we      = c_we_q;
    assign c_addr    = c_addr_q;
    assign c_in      = c_in_q;
    assign c_sect    = c_sect_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

`default_nettype wire
